// File: rtl/muldiv_defs.sv
// Shared op and state encodings for the iterative multiply/divide unit,
// plus the operand magnitude helper used by the control logic.
`ifndef MULDIV_DEFS_SV
`define MULDIV_DEFS_SV
package muldiv_defs;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int CNT_W = 6;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage
`endif

// File: rtl/muldiv_core.sv
// 64-bit accumulator/shifter: one shift-add (multiply) or restoring
// shift-subtract (divide) step per asserted step cycle on unsigned magnitudes.
module muldiv_core (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic        load_div,
  input  logic        step,
  input  logic [31:0] a_mag,
  input  logic [31:0] b_mag,
  output logic [31:0] acc_hi,
  output logic [31:0] acc_lo
);

  logic [31:0] m_reg;
  logic        div_reg;
  logic [32:0] sum;
  logic [32:0] shifted;
  logic [31:0] trial;
  logic        ge;

  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m_reg} : 33'd0);
    shifted = {acc_hi, acc_lo[31]};
    // When ge holds the true difference fits in 32 bits, so the wrap is harmless.
    trial   = shifted[31:0] - m_reg;
    ge      = shifted[32] | (shifted[31:0] >= m_reg);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_reg   <= '0;
      div_reg <= 1'b0;
      acc_hi  <= '0;
      acc_lo  <= '0;
    end else if (load) begin
      div_reg <= load_div;
      m_reg   <= load_div ? b_mag : a_mag;
      acc_hi  <= '0;
      acc_lo  <= load_div ? a_mag : b_mag;
    end else if (step) begin
      if (div_reg) begin
        acc_hi <= ge ? trial : shifted[31:0];
        acc_lo <= {acc_lo[30:0], ge};
      end else begin
        acc_hi <= sum[32:1];
        acc_lo <= {sum[0], acc_lo[31:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multiply/divide sequencer: control FSM, sign correction and the
// architectural HI/LO registers around the iterative muldiv_core.
module muldiv_sequencer
  import muldiv_defs::*;
#(
  parameter int ITER = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        MfOpInD,
  output logic        busy,
  output logic        done,
  output logic [31:0] reg_hi,
  output logic [31:0] reg_lo,
  output logic        mf_stall
);

  localparam logic [CNT_W-1:0] ITER_C = CNT_W'(ITER);

  state_t           state;
  op_t              op_q;
  logic [31:0]      a_q;
  logic             a_neg_q;
  logic             b_neg_q;
  logic             b_zero_q;
  logic [CNT_W-1:0] cnt;

  logic        accept;
  logic        step;
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;
  logic [63:0] neg_prod;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  assign accept   = start && (state == ST_IDLE || state == ST_DONE);
  assign step     = (state == ST_RUN) && (cnt < ITER_C);
  assign mf_stall = MfOpInD & (busy | start);

  muldiv_core u_core (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (accept),
    .load_div (op[1]),
    .step     (step),
    .a_mag    (mag32(src_a, ~op[0])),
    .b_mag    (mag32(src_b, ~op[0])),
    .acc_hi   (acc_hi),
    .acc_lo   (acc_lo)
  );

  always_comb begin
    neg_prod = ~{acc_hi, acc_lo} + 64'd1;
    fix_hi   = acc_hi;
    fix_lo   = acc_lo;
    case (op_q)
      OP_MULT: if (a_neg_q ^ b_neg_q) {fix_hi, fix_lo} = neg_prod;
      OP_DIV: begin
        if (a_neg_q ^ b_neg_q) fix_lo = ~acc_lo + 32'd1;
        if (a_neg_q)           fix_hi = ~acc_hi + 32'd1;
      end
      default: ;
    endcase
    // Divide by zero returns the raw dividend rather than its magnitude.
    if (b_zero_q) begin
      fix_hi = a_q;
      fix_lo = 32'hFFFF_FFFF;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      op_q     <= OP_MULT;
      a_q      <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      reg_hi   <= '0;
      reg_lo   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            op_q     <= op_t'(op);
            a_q      <= src_a;
            a_neg_q  <= ~op[0] & src_a[31];
            b_neg_q  <= ~op[0] & src_b[31];
            b_zero_q <= op[1] & (src_b == 32'd0);
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= ST_RUN;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (cnt < ITER_C) cnt <= cnt + 1'b1;
          else              state <= ST_FIXUP;
        end
        ST_FIXUP: begin
          reg_hi <= fix_hi;
          reg_lo <= fix_lo;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: arithmetic reference model with a
// per-cycle compare process, plus directed vectors with literal expectations.
module tb_muldiv_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        MfOpInD;
  logic        busy;
  logic        done;
  logic [31:0] reg_hi;
  logic [31:0] reg_lo;
  logic        mf_stall;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clock = ~clock;

  muldiv_sequencer #(.ITER(32)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .MfOpInD  (MfOpInD),
    .busy     (busy),
    .done     (done),
    .reg_hi   (reg_hi),
    .reg_lo   (reg_lo),
    .mf_stall (mf_stall)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    longint          q, r;
    longint unsigned uq, ur;
    logic [63:0]     res;
    case (o)
      2'd0: res = 64'(sa * sb);
      2'd1: res = 64'(ua * ub);
      2'd2: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          res = {ur[31:0], uq[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  // Model: age counts edges since acceptance; result lands 34 edges later.
  int          m_age = -1;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] p_hi = '0;
  logic [31:0] p_lo = '0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_age = -1;
      m_hi  = '0;
      m_lo  = '0;
    end else if (m_age >= 0 && m_age < 34) begin
      m_age++;
      if (m_age == 34) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (start) begin
      m_age = 0;
      {p_hi, p_lo} = ref_result(op, src_a, src_b);
    end else begin
      m_age = -1;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      logic exp_busy;
      exp_busy = (m_age >= 0 && m_age < 34);
      chk("busy", 64'(busy), 64'(exp_busy));
      chk("done", 64'(done), 64'(m_age == 34));
      chk("reg_hi", 64'(reg_hi), 64'(m_hi));
      chk("reg_lo", 64'(reg_lo), 64'(m_lo));
      chk("mf_stall", 64'(mf_stall), 64'(MfOpInD & (exp_busy | start)));
    end
  end

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clock); #1;
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 60;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit lit, input logic [31:0] eh,
                        input logic [31:0] el);
    int lat;
    launch(o, a, b);
    wait_done(lat);
    chk({name, " latency"}, 64'(lat), 64'd34);
    if (lit) begin
      chk({name, " hi"}, 64'(reg_hi), 64'(eh));
      chk({name, " lo"}, 64'(reg_lo), 64'(el));
    end
    $display("%s op=%0d a=%h b=%h hi=%h lo=%h lat=%0d", name, o, a, b, reg_hi, reg_lo, lat);
  endtask

  initial begin
    int lat, stall_cnt, done_at, done_cnt;
    reset_n = 1'b0; start = 1'b0; op = 2'd0; src_a = '0; src_b = '0; MfOpInD = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clock);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset hi", 64'(reg_hi), 64'd0);
    chk("reset lo", 64'(reg_lo), 64'd0);

    run_op("mult_m1x2",  2'd0, 32'hFFFF_FFFF, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu_m1x2", 2'd1, 32'hFFFF_FFFF, 32'd2, 1, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("mult_m3xm5", 2'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 1, 32'd0, 32'd15);
    run_op("div_m7d2",   2'd2, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7dm2",   2'd2, 32'd7, 32'hFFFF_FFFE, 1, 32'd1, 32'hFFFF_FFFD);
    run_op("divu_7d0",   2'd3, 32'd7, 32'd0, 1, 32'd7, 32'hFFFF_FFFF);
    run_op("div_m7d0",   2'd2, 32'hFFFF_FFF9, 32'd0, 1, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div_ovf",    2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, 32'h8000_0000);
    run_op("mult_mix",   2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 0, 32'd0, 32'd0);
    run_op("multu_big",  2'd1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0, 32'd0, 32'd0);
    run_op("div_mix",    2'd2, 32'h8000_0001, 32'd7, 0, 32'd0, 32'd0);
    run_op("divu_big",   2'd3, 32'hFFFF_FFFF, 32'd10, 0, 32'd0, 32'd0);

    // Stall window with a second, ignored start ten cycles in.
    @(posedge clock); #1;
    MfOpInD = 1'b1; start = 1'b1; op = 2'd3; src_a = 32'd100; src_b = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    stall_cnt = 0;
    done_at = -1;
    for (int i = 0; i <= 34; i++) begin
      if (i == 9) begin start = 1'b1; op = 2'd0; src_a = 32'd5; src_b = 32'd5; end
      if (i == 10) start = 1'b0;
      @(negedge clock);
      stall_cnt += int'(mf_stall);
      if (done) done_at = i;
      if (i == 34) chk("stall at done", 64'(mf_stall), 64'd0);
      @(posedge clock); #1;
    end
    MfOpInD = 1'b0;
    chk("stall cycles", 64'(stall_cnt), 64'd34);
    chk("stall done_at", 64'(done_at), 64'd34);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      done_cnt += int'(done);
    end
    chk("ignored start no done", 64'(done_cnt), 64'd0);
    chk("divu_100d7 hi", 64'(reg_hi), 64'd2);
    chk("divu_100d7 lo", 64'(reg_lo), 64'd14);
    $display("stall_test stall_cycles=%0d done_at=%0d hi=%h lo=%h", stall_cnt, done_at, reg_hi, reg_lo);

    // Reset in the middle of a DIV with HI/LO holding nonzero values.
    launch(2'd2, 32'd1000, 32'd3);
    repeat (14) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort hi", 64'(reg_hi), 64'd0);
    chk("abort lo", 64'(reg_lo), 64'd0);
    @(posedge clock); #1 reset_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      done_cnt += int'(done);
    end
    chk("abort no done", 64'(done_cnt), 64'd0);
    chk("abort hi after", 64'(reg_hi), 64'd0);
    chk("abort lo after", 64'(reg_lo), 64'd0);
    $display("reset_abort done_pulses=%0d hi=%h lo=%h", done_cnt, reg_hi, reg_lo);

    // Start presented together with reset release is taken at the next edge.
    @(posedge clock); #1 reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1; start = 1'b1; op = 2'd1; src_a = 32'd3; src_b = 32'd5;
    @(posedge clock); #1 start = 1'b0;
    wait_done(lat);
    chk("post_reset latency", 64'(lat), 64'd34);
    chk("post_reset lo", 64'(reg_lo), 64'd15);
    $display("post_reset_multu op=1 a=3 b=5 hi=%h lo=%h lat=%0d", reg_hi, reg_lo, lat);

    // Back-to-back: next start presented during the DONE cycle.
    launch(2'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat);
    chk("b2b first latency", 64'(lat), 64'd34);
    chk("b2b first lo", 64'(reg_lo), 64'(32'hFFFF_FFFD));
    #1;
    start = 1'b1; op = 2'd1; src_a = 32'd3; src_b = 32'd5;
    @(posedge clock); #1 start = 1'b0;
    wait_done(lat);
    chk("b2b second latency", 64'(lat), 64'd34);
    chk("b2b second hi", 64'(reg_hi), 64'd0);
    chk("b2b second lo", 64'(reg_lo), 64'd15);
    $display("b2b_multu op=1 a=3 b=5 hi=%h lo=%h lat=%0d", reg_hi, reg_lo, lat);

    repeat (2) @(posedge clock);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
